target_box_overlay: RTL and testbench

Draws the bounding boxes from the multi-target detector as coloured rectangular outlines on the 24-bit RGB video stream before HDMI output. Takes up to two 43-bit target descriptors in the detector's `{flag, ymax, xmax, ymin, xmin}` format. Box coordinates are frozen at each frame start, so a mid-frame descriptor update never tears a box. The video timing signals pass through with a fixed two-cycle delay.

---
 rtl/target_box_overlay.sv | 178 +++++++++++++++++
 tb/tb_target_box_overlay.sv | 509 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/target_box_overlay.sv
// target_box_overlay: draws up to two detector boxes as outlines on an
// RGB888 stream; timing and pixel data both see exactly two register stages.
module target_box_overlay #(
  parameter logic [10:0] IMG_HDISP  = 11'd1280,
  parameter logic [9:0]  IMG_VDISP  = 10'd720,
  parameter logic [2:0]  LINE_W     = 3'd2,
  parameter logic [23:0] BOX_COLOR1 = 24'hFF0000,
  parameter logic [23:0] BOX_COLOR2 = 24'h00FF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [23:0] per_img_data,
  input  logic [42:0] target_pos_in1,
  input  logic [42:0] target_pos_in2,
  input  logic        overlay_en,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic [23:0] post_img_data
);

  localparam logic [10:0] X_LAST = IMG_HDISP - 11'd1;
  localparam logic [9:0]  Y_LAST = IMG_VDISP - 10'd1;
  localparam logic [10:0] LW_X   = {8'd0, LINE_W};
  localparam logic [9:0]  LW_Y   = {7'd0, LINE_W};

  function automatic logic f_valid(input logic [42:0] d);
    logic [10:0] xmin;
    logic [10:0] xmax;
    logic [9:0]  ymin;
    logic [9:0]  ymax;
    xmin = d[10:0];
    ymin = d[20:11];
    xmax = d[31:21];
    ymax = d[41:32];
    return d[42] && (xmin <= xmax) && (ymin <= ymax) &&
           (xmax <= X_LAST) && (ymax <= Y_LAST);
  endfunction

  // Differences are only taken once the pixel is known to be inside.
  function automatic logic f_edge(
    input logic [42:0] d,
    input logic [10:0] x,
    input logic [9:0]  y
  );
    logic [10:0] xmin;
    logic [10:0] xmax;
    logic [9:0]  ymin;
    logic [9:0]  ymax;
    logic        in_box;
    logic        near;
    xmin   = d[10:0];
    ymin   = d[20:11];
    xmax   = d[31:21];
    ymax   = d[41:32];
    in_box = (x >= xmin) && (x <= xmax) &&
             (y >= ymin) && (y <= ymax);
    near   = 1'b0;
    if (in_box) begin
      near = ((x - xmin) < LW_X) || ((xmax - x) < LW_X) ||
             ((y - ymin) < LW_Y) || ((ymax - y) < LW_Y);
    end
    return in_box && near;
  endfunction

  logic        r_vs_prev;
  logic        r_armed;
  logic        r_en;
  logic        r_ok1;
  logic        r_ok2;
  logic [42:0] r_box1;
  logic [42:0] r_box2;
  logic [10:0] r_x;
  logic [9:0]  r_y;

  logic        r_vs1;
  logic        r_hs1;
  logic        r_ck1;
  logic        r_hit1;
  logic        r_hit2;
  logic [23:0] r_data1;

  logic        w_fs;
  logic        w_en;
  logic        w_ok1;
  logic        w_ok2;
  logic [42:0] w_box1;
  logic [42:0] w_box2;
  logic        w_pix;
  logic        w_hit1;
  logic        w_hit2;

  // r_armed blocks a false frame start when reset releases mid-frame.
  assign w_fs   = per_frame_vsync & ~r_vs_prev & r_armed;
  assign w_en   = w_fs ? overlay_en : r_en;
  assign w_box1 = w_fs ? target_pos_in1 : r_box1;
  assign w_box2 = w_fs ? target_pos_in2 : r_box2;
  assign w_ok1  = w_fs ? f_valid(target_pos_in1) : r_ok1;
  assign w_ok2  = w_fs ? f_valid(target_pos_in2) : r_ok2;
  assign w_pix  = per_frame_vsync & per_frame_clken & w_en;
  assign w_hit1 = w_pix & w_ok1 & f_edge(w_box1, r_x, r_y);
  assign w_hit2 = w_pix & w_ok2 & f_edge(w_box2, r_x, r_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev <= 1'b0;
      r_armed   <= 1'b0;
      r_en      <= 1'b0;
      r_ok1     <= 1'b0;
      r_ok2     <= 1'b0;
      r_box1    <= '0;
      r_box2    <= '0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_vs_prev <= per_frame_vsync;
      if (!per_frame_vsync) begin
        r_armed <= 1'b1;
      end
      if (w_fs) begin
        r_en   <= overlay_en;
        r_box1 <= target_pos_in1;
        r_box2 <= target_pos_in2;
        r_ok1  <= f_valid(target_pos_in1);
        r_ok2  <= f_valid(target_pos_in2);
      end
      if (!per_frame_vsync || !r_armed) begin
        r_x <= '0;
        r_y <= '0;
      end else if (per_frame_clken) begin
        if (r_x < X_LAST) begin
          r_x <= r_x + 11'd1;
        end else begin
          r_x <= '0;
          if (r_y != 10'd1023) begin
            r_y <= r_y + 10'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs1            <= 1'b0;
      r_hs1            <= 1'b0;
      r_ck1            <= 1'b0;
      r_hit1           <= 1'b0;
      r_hit2           <= 1'b0;
      r_data1          <= '0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_data    <= '0;
    end else begin
      r_vs1            <= per_frame_vsync;
      r_hs1            <= per_frame_href;
      r_ck1            <= per_frame_clken;
      r_hit1           <= w_hit1;
      r_hit2           <= w_hit2;
      r_data1          <= per_img_data;
      post_frame_vsync <= r_vs1;
      post_frame_href  <= r_hs1;
      post_frame_clken <= r_ck1;
      if (r_hit1) begin
        post_img_data <= BOX_COLOR1;
      end else if (r_hit2) begin
        post_img_data <= BOX_COLOR2;
      end else begin
        post_img_data <= r_data1;
      end
    end
  end

endmodule

// File: tb/tb_target_box_overlay.sv
// Bench for target_box_overlay: three instances (LINE_W 2/1/4) share
// stimulus; a monitor files output pixels by position for directed checks.
module tb_target_box_overlay;

  localparam int NL = 24;
  localparam logic [23:0] RED  = 24'hFF0000;
  localparam logic [23:0] GRN  = 24'h00FF00;
  localparam logic [23:0] GAPD = 24'hABCDEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        per_frame_vsync;
  logic        per_frame_href;
  logic        per_frame_clken;
  logic [23:0] per_img_data;
  logic [42:0] target_pos_in1;
  logic [42:0] target_pos_in2;
  logic        overlay_en;

  logic        o_vs [3];
  logic        o_hs [3];
  logic        o_ck [3];
  logic [23:0] o_data [3];

  logic [23:0] mem [3][NL][1280];
  int          mx [3];
  int          my [3];
  int          gap_cnt [3];
  logic [23:0] gap_data [3];

  logic [42:0] new_d1;
  logic [42:0] new_d2;
  logic        new_en;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          k;
    int          x;
    int          y;
    logic [23:0] e;
  } pchk_t;

  always #5 clk = ~clk;

  target_box_overlay u_lw2 (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_data(per_img_data),
    .target_pos_in1(target_pos_in1), .target_pos_in2(target_pos_in2),
    .overlay_en(overlay_en),
    .post_frame_vsync(o_vs[0]), .post_frame_href(o_hs[0]),
    .post_frame_clken(o_ck[0]), .post_img_data(o_data[0])
  );

  target_box_overlay #(.LINE_W(3'd1)) u_lw1 (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_data(per_img_data),
    .target_pos_in1(target_pos_in1), .target_pos_in2(target_pos_in2),
    .overlay_en(overlay_en),
    .post_frame_vsync(o_vs[1]), .post_frame_href(o_hs[1]),
    .post_frame_clken(o_ck[1]), .post_img_data(o_data[1])
  );

  target_box_overlay #(.LINE_W(3'd4)) u_lw4 (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_data(per_img_data),
    .target_pos_in1(target_pos_in1), .target_pos_in2(target_pos_in2),
    .overlay_en(overlay_en),
    .post_frame_vsync(o_vs[2]), .post_frame_href(o_hs[2]),
    .post_frame_clken(o_ck[2]), .post_img_data(o_data[2])
  );

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 3; k++) begin
      if (!o_vs[k]) begin
        mx[k] = 0;
        my[k] = 0;
      end else if (o_ck[k]) begin
        if (my[k] < NL) mem[k][my[k]][mx[k]] = o_data[k];
        if (mx[k] == 1279) begin
          mx[k] = 0;
          my[k] = my[k] + 1;
        end else begin
          mx[k] = mx[k] + 1;
        end
      end else if (o_hs[k]) begin
        gap_data[k] = o_data[k];
        gap_cnt[k]  = gap_cnt[k] + 1;
      end
    end
  end

  function automatic logic [23:0] pat(input int x, input int y);
    logic [9:0]  yy;
    logic [10:0] xx;
    yy = y[9:0];
    xx = x[10:0];
    return {3'b000, yy, xx};
  endfunction

  function automatic pchk_t mk(input int k, input int x, input int y,
                               input logic [23:0] e);
    pchk_t p;
    p.k = k;
    p.x = x;
    p.y = y;
    p.e = e;
    return p;
  endfunction

  task automatic drive_frame(input int nl, input bit zero,
                             input int gap_y, input int chg_line);
    for (int k = 0; k < 3; k++) begin
      gap_cnt[k]  = 0;
      gap_data[k] = '0;
      for (int y = 0; y < NL; y++)
        for (int x = 0; x < 1280; x++) mem[k][y][x] = 24'h5A5A5A;
    end
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_data    = '0;
    repeat (4) @(negedge clk);
    for (int y = 0; y < nl; y++) begin
      if (y == chg_line) begin
        target_pos_in1 = new_d1;
        target_pos_in2 = new_d2;
        overlay_en     = new_en;
      end
      for (int x = 0; x < 1280; x++) begin
        per_frame_vsync = 1'b1;
        per_frame_href  = 1'b1;
        per_frame_clken = 1'b1;
        per_img_data    = zero ? 24'h0 : pat(x, y);
        @(negedge clk);
        if (y == gap_y && x == 10) begin
          per_frame_clken = 1'b0;
          per_img_data    = GAPD;
          @(negedge clk);
        end
      end
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      per_img_data    = '0;
      repeat (4) @(negedge clk);
    end
    per_frame_vsync = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n           = 1'b0;
    per_frame_vsync = 1'b1;
    per_frame_href  = 1'b1;
    per_frame_clken = 1'b1;
    per_img_data    = 24'hFFFFFF;
    target_pos_in1  = {1'b1, 10'd5, 11'd5, 10'd0, 11'd0};
    target_pos_in2  = '0;
    overlay_en      = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({o_vs[k], o_hs[k], o_ck[k], o_data[k]} !== 27'h0) begin
        n_fail++;
        $display("FAIL reset inst%0d got vs=%b hs=%b ck=%b d=%h want all 0",
                 k, o_vs[k], o_hs[k], o_ck[k], o_data[k]);
      end
    end
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_data    = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency;
    int          lat;
    logic [23:0] d_at;
    logic        ck_at;
    target_pos_in1 = '0;
    target_pos_in2 = '0;
    overlay_en     = 1'b0;
    @(negedge clk);
    per_frame_href  = 1'b1;
    per_frame_clken = 1'b1;
    per_img_data    = 24'h123456;
    lat   = 0;
    d_at  = '0;
    ck_at = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_data    = '0;
      end
      if (lat == 0 && o_hs[0] === 1'b1) begin
        lat   = c;
        d_at  = o_data[0];
        ck_at = o_ck[0];
      end
    end
    n_checks++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL lat_href got=%0d want=2", lat);
    end
    n_checks++;
    if (d_at !== 24'h123456) begin
      n_fail++;
      $display("FAIL lat_data got=%h want=123456", d_at);
    end
    n_checks++;
    if (ck_at !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_clken got=%b want=1", ck_at);
    end
    @(negedge clk);
    per_frame_vsync = 1'b1;
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) per_frame_vsync = 1'b0;
      if (lat == 0 && o_vs[0] === 1'b1) lat = c;
    end
    n_checks++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL lat_vsync got=%0d want=2", lat);
    end
    @(negedge clk);
  endtask

  task automatic test_outline_priority;
    pchk_t t[$];
    target_pos_in1 = {1'b1, 10'd20, 11'd30, 10'd10, 11'd10};
    target_pos_in2 = {1'b1, 10'd15, 11'd60, 10'd5, 11'd25};
    overlay_en     = 1'b1;
    drive_frame(22, 1'b1, 15, -1);
    t.push_back(mk(1, 10, 10, RED));
    t.push_back(mk(1, 20, 10, RED));
    t.push_back(mk(1, 30, 10, RED));
    t.push_back(mk(1, 10, 20, RED));
    t.push_back(mk(1, 30, 20, RED));
    t.push_back(mk(1, 10, 15, RED));
    t.push_back(mk(1, 30, 15, RED));
    t.push_back(mk(1, 11, 11, 24'h0));
    t.push_back(mk(1, 9, 10, 24'h0));
    t.push_back(mk(1, 31, 20, 24'h0));
    t.push_back(mk(1, 20, 21, 24'h0));
    t.push_back(mk(1, 25, 10, RED));
    t.push_back(mk(1, 40, 5, GRN));
    t.push_back(mk(1, 25, 5, GRN));
    t.push_back(mk(1, 60, 15, GRN));
    t.push_back(mk(1, 60, 10, GRN));
    t.push_back(mk(1, 26, 12, 24'h0));
    t.push_back(mk(1, 45, 16, 24'h0));
    t.push_back(mk(0, 11, 11, RED));
    t.push_back(mk(0, 12, 12, 24'h0));
    t.push_back(mk(0, 26, 12, GRN));
    t.push_back(mk(2, 13, 13, RED));
    t.push_back(mk(2, 14, 14, 24'h0));
    t.push_back(mk(2, 27, 13, RED));
    foreach (t[i]) begin
      n_checks++;
      if (mem[t[i].k][t[i].y][t[i].x] !== t[i].e) begin
        n_fail++;
        $display("FAIL outline[%0d] inst%0d px(%0d,%0d) got=%h want=%h",
                 i, t[i].k, t[i].x, t[i].y,
                 mem[t[i].k][t[i].y][t[i].x], t[i].e);
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (gap_cnt[k] != 1 || gap_data[k] !== GAPD) begin
        n_fail++;
        $display("FAIL unstrobed inst%0d got cnt=%0d d=%h want cnt=1 d=%h",
                 k, gap_cnt[k], gap_data[k], GAPD);
      end
    end
  endtask

  task automatic test_no_tearing;
    pchk_t t[$];
    pchk_t u[$];
    target_pos_in1 = {1'b1, 10'd4, 11'd100, 10'd0, 11'd90};
    target_pos_in2 = '0;
    overlay_en     = 1'b1;
    new_d1 = {1'b1, 10'd4, 11'd200, 10'd0, 11'd190};
    new_d2 = {1'b1, 10'd1, 11'd500, 10'd1, 11'd500};
    new_en = 1'b1;
    drive_frame(5, 1'b0, -1, 2);
    t.push_back(mk(0, 90, 3, RED));
    t.push_back(mk(0, 95, 0, RED));
    t.push_back(mk(0, 100, 1, RED));
    t.push_back(mk(0, 95, 2, pat(95, 2)));
    t.push_back(mk(0, 190, 3, pat(190, 3)));
    t.push_back(mk(0, 190, 0, pat(190, 0)));
    t.push_back(mk(0, 500, 1, pat(500, 1)));
    foreach (t[i]) begin
      n_checks++;
      if (mem[t[i].k][t[i].y][t[i].x] !== t[i].e) begin
        n_fail++;
        $display("FAIL tear_old[%0d] px(%0d,%0d) got=%h want=%h",
                 i, t[i].x, t[i].y, mem[t[i].k][t[i].y][t[i].x], t[i].e);
      end
    end
    drive_frame(5, 1'b0, -1, -1);
    u.push_back(mk(0, 190, 0, RED));
    u.push_back(mk(0, 200, 2, RED));
    u.push_back(mk(0, 195, 2, pat(195, 2)));
    u.push_back(mk(0, 90, 0, pat(90, 0)));
    u.push_back(mk(0, 95, 4, pat(95, 4)));
    u.push_back(mk(0, 500, 1, GRN));
    u.push_back(mk(0, 499, 1, pat(499, 1)));
    u.push_back(mk(0, 501, 1, pat(501, 1)));
    u.push_back(mk(0, 500, 0, pat(500, 0)));
    u.push_back(mk(0, 500, 2, pat(500, 2)));
    foreach (u[i]) begin
      n_checks++;
      if (mem[u[i].k][u[i].y][u[i].x] !== u[i].e) begin
        n_fail++;
        $display("FAIL tear_new[%0d] px(%0d,%0d) got=%h want=%h",
                 i, u[i].x, u[i].y, mem[u[i].k][u[i].y][u[i].x], u[i].e);
      end
    end
  endtask

  task automatic test_invalid;
    logic [42:0] c1 [4];
    logic [42:0] c2 [4];
    logic        ce [4];
    int          px [5];
    int          py [5];
    int          k;
    c1[0] = {1'b0, 10'd2, 11'd30, 10'd0, 11'd10};
    c1[1] = {1'b1, 10'd2, 11'd30, 10'd0, 11'd40};
    c1[2] = {1'b1, 10'd2, 11'd30, 10'd0, 11'd10};
    c1[3] = {1'b1, 10'd2, 11'd1280, 10'd0, 11'd10};
    c2[0] = '0;
    c2[1] = '0;
    c2[2] = {1'b1, 10'd2, 11'd60, 10'd0, 11'd50};
    c2[3] = {1'b1, 10'd720, 11'd60, 10'd0, 11'd40};
    ce[0] = 1'b1;
    ce[1] = 1'b1;
    ce[2] = 1'b0;
    ce[3] = 1'b1;
    px[0] = 10; py[0] = 0;
    px[1] = 30; py[1] = 1;
    px[2] = 20; py[2] = 2;
    px[3] = 40; py[3] = 0;
    px[4] = 50; py[4] = 1;
    for (int c = 0; c < 4; c++) begin
      target_pos_in1 = c1[c];
      target_pos_in2 = c2[c];
      overlay_en     = ce[c];
      new_d1 = c1[c];
      new_d2 = c2[c];
      new_en = 1'b1;
      drive_frame(3, 1'b0, -1, (c == 2) ? 1 : -1);
      for (int j = 0; j < 10; j++) begin
        k = (j < 5) ? 0 : 2;
        n_checks++;
        if (mem[k][py[j%5]][px[j%5]] !== pat(px[j%5], py[j%5])) begin
          n_fail++;
          $display("FAIL invalid case%0d inst%0d px(%0d,%0d) got=%h want=%h",
                   c, k, px[j%5], py[j%5], mem[k][py[j%5]][px[j%5]],
                   pat(px[j%5], py[j%5]));
        end
      end
    end
  endtask

  task automatic test_edge_degenerate;
    pchk_t t[$];
    target_pos_in1 = {1'b1, 10'd9, 11'd1279, 10'd0, 11'd0};
    target_pos_in2 = {1'b1, 10'd8, 11'd104, 10'd1, 11'd100};
    overlay_en     = 1'b1;
    drive_frame(10, 1'b0, -1, -1);
    t.push_back(mk(2, 0, 0, RED));
    t.push_back(mk(2, 3, 4, RED));
    t.push_back(mk(2, 4, 4, pat(4, 4)));
    t.push_back(mk(2, 1275, 4, pat(1275, 4)));
    t.push_back(mk(2, 1276, 4, RED));
    t.push_back(mk(2, 1279, 4, RED));
    t.push_back(mk(2, 640, 4, pat(640, 4)));
    t.push_back(mk(2, 640, 3, RED));
    t.push_back(mk(2, 640, 9, RED));
    t.push_back(mk(2, 100, 4, GRN));
    t.push_back(mk(2, 102, 4, GRN));
    t.push_back(mk(2, 104, 4, GRN));
    t.push_back(mk(2, 99, 4, pat(99, 4)));
    t.push_back(mk(2, 105, 4, pat(105, 4)));
    t.push_back(mk(0, 1, 4, RED));
    t.push_back(mk(0, 2, 4, pat(2, 4)));
    t.push_back(mk(0, 1277, 4, pat(1277, 4)));
    t.push_back(mk(0, 1278, 4, RED));
    t.push_back(mk(0, 0, 5, RED));
    t.push_back(mk(0, 100, 4, GRN));
    t.push_back(mk(0, 102, 4, pat(102, 4)));
    t.push_back(mk(0, 103, 4, GRN));
    t.push_back(mk(0, 640, 1, RED));
    t.push_back(mk(0, 640, 2, pat(640, 2)));
    t.push_back(mk(1, 0, 4, RED));
    t.push_back(mk(1, 1, 4, pat(1, 4)));
    t.push_back(mk(1, 1279, 4, RED));
    t.push_back(mk(1, 1278, 4, pat(1278, 4)));
    t.push_back(mk(1, 102, 1, GRN));
    foreach (t[i]) begin
      n_checks++;
      if (mem[t[i].k][t[i].y][t[i].x] !== t[i].e) begin
        n_fail++;
        $display("FAIL edge[%0d] inst%0d px(%0d,%0d) got=%h want=%h",
                 i, t[i].k, t[i].x, t[i].y,
                 mem[t[i].k][t[i].y][t[i].x], t[i].e);
      end
    end
  endtask

  task automatic test_mid_reset;
    pchk_t t[$];
    int    red_cnt;
    bit    released;
    target_pos_in1 = {1'b1, 10'd2, 11'd20, 10'd0, 11'd10};
    target_pos_in2 = '0;
    overlay_en     = 1'b1;
    red_cnt  = 0;
    released = 1'b0;
    per_frame_vsync = 1'b0;
    repeat (4) @(negedge clk);
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 1280; x++) begin
        if (y == 1 && x == 300) begin
          rst_n = 1'b0;
          #1;
          for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            for (int k = 0; k < 3; k++) begin
              n_checks++;
              if ({o_vs[k], o_hs[k], o_ck[k], o_data[k]} !== 27'h0) begin
                n_fail++;
                $display("FAIL midreset c%0d inst%0d got vs=%b hs=%b ck=%b d=%h want 0",
                         c, k, o_vs[k], o_hs[k], o_ck[k], o_data[k]);
              end
            end
          end
          rst_n    = 1'b1;
          released = 1'b1;
        end
        per_frame_vsync = 1'b1;
        per_frame_href  = 1'b1;
        per_frame_clken = 1'b1;
        per_img_data    = pat(x, y);
        @(negedge clk);
        if (released && (o_data[0] === RED || o_data[2] === RED))
          red_cnt++;
      end
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      per_img_data    = '0;
      repeat (4) @(negedge clk);
    end
    per_frame_vsync = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (red_cnt != 0) begin
      n_fail++;
      $display("FAIL postreset_nodraw got=%0d red px want=0", red_cnt);
    end
    drive_frame(3, 1'b0, -1, -1);
    t.push_back(mk(0, 10, 0, RED));
    t.push_back(mk(0, 15, 0, RED));
    t.push_back(mk(0, 9, 0, pat(9, 0)));
    t.push_back(mk(0, 21, 1, pat(21, 1)));
    t.push_back(mk(0, 20, 1, RED));
    t.push_back(mk(2, 15, 2, RED));
    foreach (t[i]) begin
      n_checks++;
      if (mem[t[i].k][t[i].y][t[i].x] !== t[i].e) begin
        n_fail++;
        $display("FAIL afterreset[%0d] inst%0d px(%0d,%0d) got=%h want=%h",
                 i, t[i].k, t[i].x, t[i].y,
                 mem[t[i].k][t[i].y][t[i].x], t[i].e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_outline_priority();
    test_no_tearing();
    test_invalid();
    test_edge_degenerate();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
